dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (19-bit address, 19-bit data, WE, Cant_Byte byte/halfword select) between two requesters.
- Requester 0 is the CPU load/store unit: single beats, fixed priority.
- Requester 1 is the image DMA/loader: bursts of sequential beats.
- Sits between both requesters and the data memory. Drives the memory address, write-data and control inputs, and returns registered read data.

Parameters:
- AW, 19, address and data width of the memory port.
- LENW, 4, width of the burst-length field; maximum burst is 2^LENW-1 beats.
- STARVE_LIMIT, 4, consecutive r0 grants allowed while r1_req is high before r1 is forced through.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- r0_req  in  1  CPU beat request; held high with r0_addr/r0_we/r0_size/r0_wdata stable until r0_gnt.
- r0_we  in  1  1=write, 0=read.
- r0_size  in  1  0=byte, 1=halfword (maps to Cant_Byte).
- r0_addr  in  AW  byte address.
- r0_wdata  in  AW  write data.
- r0_gnt  out  1  beat executed this cycle.
- r0_rvalid  out  1  one-cycle pulse; r0_rdata valid.
- r0_rdata  out  AW  registered read data.
- r1_req  in  1  DMA burst request; held high with parameters stable until r1_done.
- r1_we, r1_size  in  1 each  as for r0; apply to the whole burst.
- r1_addr  in  AW  burst start byte address.
- r1_len  in  LENW  beat count; 0 is treated as 1.
- r1_wdata  in  AW  write data for the current beat; sampled in each cycle r1_gnt=1.
- r1_gnt  out  1  a burst beat executes this cycle.
- r1_done  out  1  high on the last beat of the burst.
- r1_rvalid  out  1  one-cycle pulse per read beat.
- r1_rdata  out  AW  registered read data.
- mem_A  out  AW  to memory address.
- mem_WD  out  AW  to memory write data.
- mem_WE  out  1  to memory write enable.
- mem_Cant_Byte  out  1  to memory size select.
- mem_RD  in  AW  memory combinational read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; starve counter and beat counter clear to 0.
  - All gnt, done and rvalid outputs are 0; rdata registers are 0.
  - mem_WE=0 takes effect immediately, so a write in progress is aborted; no memory write occurs on an edge while reset=0.
  - A burst interrupted by reset is abandoned; r1 must re-request.
- FSM states: IDLE, GNT0, BURST1.
- IDLE arbitration, evaluated every cycle:
  - If r1_req and (not r0_req, or starve==STARVE_LIMIT) -> BURST1. Latch base=r1_addr, len=max(r1_len,1), we, size; beat counter=0; starve=0.
  - Else if r0_req -> GNT0. If r1_req, starve increments, saturating at STARVE_LIMIT.
  - Else stay in IDLE.
- GNT0 (exactly 1 cycle):
  - r0_gnt=1; mem_* driven from r0_* (mem_Cant_Byte=r0_size); mem_WE=r0_we.
  - Next state is IDLE. There is one mandatory idle bubble between any two grants.
- BURST1:
  - One beat per cycle, r1_gnt=1.
  - mem_A = base + beat*(size?2:1), modulo 2^AW (wraps past 0x7FFFF to 0).
  - mem_WD = r1_wdata; mem_WE = latched we; mem_Cant_Byte = latched size.
  - r1_done=1 when beat==len-1; next state is then IDLE. Otherwise beat increments.
  - r0 cannot preempt a burst.
- In IDLE: mem_WE=0, mem_A=0, mem_WD=0, mem_Cant_Byte=0.
- Read return:
  - On the rising edge ending a read beat, mem_RD is captured into rX_rdata and rX_rvalid=1 for the following cycle only.
  - Burst reads return pipelined, one pulse per beat.
  - Write beats produce no rvalid.
- r1_req dropping mid-burst is ignored: the burst completes with the latched length.
- If r0_req and r1_req rise in the same cycle and starve<STARVE_LIMIT, r0 wins.

Test Plan:
- Reset, then r0 halfword write (addr 0x10, data 0x1234, size 1), then r0 read (addr 0x10) -> r0_gnt 1 cycle after each request. Read shows r0_rvalid one cycle after gnt with r0_rdata=0x01234. Mem bus shows mem_WE=1 only during the write grant.
- r1 burst write (addr 0x100, len 4, size 1, data 0xA..0xD) -> mem_A=0x100,0x102,0x104,0x106 on 4 consecutive cycles. r1_done on the 4th beat; no r0_gnt during the burst even with r0_req high.
- r1 byte read burst (addr 0x7FFFE, len 3, size 0) -> mem_A=0x7FFFE,0x7FFFF,0x00000. Three r1_rvalid pulses, each one cycle after its beat.
- r0_req held continuously with r1_req high, STARVE_LIMIT=4 -> exactly 4 r0 grants, then the r1 burst, then r0 resumes.
- r1_len=0 -> exactly one beat, with r1_gnt and r1_done in the same cycle.
- Assert reset mid-burst during beat 2 of a write burst -> mem_WE falls immediately; state is IDLE, all outputs 0; the remaining beats never appear after reset release.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bundles both requester ports and the data-memory port shared by the arbiter.
interface dmem_port_arbiter_if #(
    parameter int unsigned AW   = 19,
    parameter int unsigned LENW = 4
);
    // requester 0: CPU load/store unit, single beats
    logic            r0_req;
    logic            r0_we;
    logic            r0_size;
    logic [AW-1:0]   r0_addr;
    logic [AW-1:0]   r0_wdata;
    logic            r0_gnt;
    logic            r0_rvalid;
    logic [AW-1:0]   r0_rdata;

    // requester 1: image DMA/loader, sequential bursts
    logic            r1_req;
    logic            r1_we;
    logic            r1_size;
    logic [AW-1:0]   r1_addr;
    logic [LENW-1:0] r1_len;
    logic [AW-1:0]   r1_wdata;
    logic            r1_gnt;
    logic            r1_done;
    logic            r1_rvalid;
    logic [AW-1:0]   r1_rdata;

    // data memory port
    logic [AW-1:0]   mem_A;
    logic [AW-1:0]   mem_WD;
    logic            mem_WE;
    logic            mem_Cant_Byte;
    logic [AW-1:0]   mem_RD;

    // arbiter side
    modport slave (
        input  r0_req, r0_we, r0_size, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_size, r1_addr, r1_len, r1_wdata,
        output r1_gnt, r1_done, r1_rvalid, r1_rdata,
        output mem_A, mem_WD, mem_WE, mem_Cant_Byte,
        input  mem_RD
    );

    // requesters plus memory side
    modport master (
        output r0_req, r0_we, r0_size, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_size, r1_addr, r1_len, r1_wdata,
        input  r1_gnt, r1_done, r1_rvalid, r1_rdata,
        input  mem_A, mem_WD, mem_WE, mem_Cant_Byte,
        output mem_RD
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: fixed-priority CPU
// beats with an anti-starvation limit, and sequential DMA bursts.
module dmem_port_arbiter #(
    parameter int unsigned AW           = 19,
    parameter int unsigned LENW         = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_port_arbiter_if.slave   bus
);
    localparam int unsigned SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, GNT0, BURST1} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [LENW-1:0] beat_q, beat_d;
    logic [LENW-1:0] len_q, len_d;
    logic [AW-1:0]   base_q, base_d;
    logic            we_q, we_d;
    logic            size_q, size_d;
    logic            r0_rvalid_q, r0_rvalid_d;
    logic [AW-1:0]   r0_rdata_q, r0_rdata_d;
    logic            r1_rvalid_q, r1_rvalid_d;
    logic [AW-1:0]   r1_rdata_q, r1_rdata_d;

    // grant and memory-bus drive follow the current state directly
    logic            r0_gnt_c, r1_gnt_c, r1_done_c;
    logic [AW-1:0]   mem_a_c, mem_wd_c, burst_off_c;
    logic            mem_we_c, mem_cb_c;

    // halfword bursts step by two bytes, byte bursts by one
    assign burst_off_c = size_q ? AW'({beat_q, 1'b0}) : AW'(beat_q);

    // state register and read-return registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            beat_q      <= '0;
            len_q       <= '0;
            base_q      <= '0;
            we_q        <= 1'b0;
            size_q      <= 1'b0;
            r0_rvalid_q <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rvalid_q <= 1'b0;
            r1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            beat_q      <= beat_d;
            len_q       <= len_d;
            base_q      <= base_d;
            we_q        <= we_d;
            size_q      <= size_d;
            r0_rvalid_q <= r0_rvalid_d;
            r0_rdata_q  <= r0_rdata_d;
            r1_rvalid_q <= r1_rvalid_d;
            r1_rdata_q  <= r1_rdata_d;
        end
    end

    // arbitration, burst sequencing and memory-bus steering
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        beat_d      = beat_q;
        len_d       = len_q;
        base_d      = base_q;
        we_d        = we_q;
        size_d      = size_q;
        r0_rvalid_d = 1'b0;
        r0_rdata_d  = r0_rdata_q;
        r1_rvalid_d = 1'b0;
        r1_rdata_d  = r1_rdata_q;
        r0_gnt_c    = 1'b0;
        r1_gnt_c    = 1'b0;
        r1_done_c   = 1'b0;
        mem_a_c     = '0;
        mem_wd_c    = '0;
        mem_we_c    = 1'b0;
        mem_cb_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.r1_req && (!bus.r0_req || starve_q == SW'(STARVE_LIMIT))) begin
                    state_d  = BURST1;
                    base_d   = bus.r1_addr;
                    len_d    = (bus.r1_len == '0) ? LENW'(1) : bus.r1_len;
                    we_d     = bus.r1_we;
                    size_d   = bus.r1_size;
                    beat_d   = '0;
                    starve_d = '0;
                end else if (bus.r0_req) begin
                    state_d = GNT0;
                    if (bus.r1_req && starve_q != SW'(STARVE_LIMIT)) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            GNT0: begin
                r0_gnt_c = 1'b1;
                mem_a_c  = bus.r0_addr;
                mem_wd_c = bus.r0_wdata;
                mem_we_c = bus.r0_we;
                mem_cb_c = bus.r0_size;
                if (!bus.r0_we) begin
                    r0_rvalid_d = 1'b1;
                    r0_rdata_d  = bus.mem_RD;
                end
                state_d = IDLE;
            end
            BURST1: begin
                r1_gnt_c = 1'b1;
                mem_a_c  = base_q + burst_off_c;
                mem_wd_c = bus.r1_wdata;
                mem_we_c = we_q;
                mem_cb_c = size_q;
                if (!we_q) begin
                    r1_rvalid_d = 1'b1;
                    r1_rdata_d  = bus.mem_RD;
                end
                if (beat_q == len_q - LENW'(1)) begin
                    r1_done_c = 1'b1;
                    state_d   = IDLE;
                end else begin
                    beat_d = beat_q + LENW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.r0_gnt        = r0_gnt_c;
    assign bus.r0_rvalid     = r0_rvalid_q;
    assign bus.r0_rdata      = r0_rdata_q;
    assign bus.r1_gnt        = r1_gnt_c;
    assign bus.r1_done       = r1_done_c;
    assign bus.r1_rvalid     = r1_rvalid_q;
    assign bus.r1_rdata      = r1_rdata_q;
    assign bus.mem_A         = mem_a_c;
    assign bus.mem_WD        = mem_wd_c;
    assign bus.mem_WE        = mem_we_c;
    assign bus.mem_Cant_Byte = mem_cb_c;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus pushes expected beats and
// read returns; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_port_arbiter;
    localparam int unsigned AW   = 19;
    localparam int unsigned LENW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.AW(AW), .LENW(LENW)) bus ();

    dmem_port_arbiter #(.AW(AW), .LENW(LENW), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // small word memory, indexed by the low 10 address bits
    logic [AW-1:0] mem [0:1023];
    assign bus.mem_RD = mem[bus.mem_A[9:0]];
    always @(posedge clk) begin
        if (bus.mem_WE) mem[bus.mem_A[9:0]] <= bus.mem_WD;
    end

    typedef struct {
        bit            who;
        logic [AW-1:0] a;
        logic [AW-1:0] wd;
        bit            we;
        bit            cb;
        bit            done;
    } beat_t;
    typedef struct {
        bit            who;
        logic [AW-1:0] d;
    } rd_t;

    beat_t beat_q[$];
    rd_t   rd_q[$];
    int    errors = 0;
    int    checks = 0;
    beat_t mb;
    rd_t   mr;

    // monitor: every cycle out of reset is either a grant beat or an idle bus
    always @(negedge clk) begin
        if (reset) begin
            if (bus.r0_gnt || bus.r1_gnt) begin
                checks++;
                if (beat_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant r0_gnt=%0b r1_gnt=%0b mem_A=%h", bus.r0_gnt, bus.r1_gnt, bus.mem_A);
                end else begin
                    mb = beat_q.pop_front();
                    if (bus.r0_gnt !== (mb.who == 1'b0) || bus.r1_gnt !== (mb.who == 1'b1) ||
                        bus.mem_A !== mb.a || bus.mem_WD !== mb.wd || bus.mem_WE !== mb.we ||
                        bus.mem_Cant_Byte !== mb.cb || bus.r1_done !== mb.done) begin
                        errors++;
                        $display("FAIL beat got r0g=%0b r1g=%0b A=%h WD=%h WE=%0b CB=%0b done=%0b exp who=%0b A=%h WD=%h WE=%0b CB=%0b done=%0b",
                                 bus.r0_gnt, bus.r1_gnt, bus.mem_A, bus.mem_WD, bus.mem_WE, bus.mem_Cant_Byte, bus.r1_done,
                                 mb.who, mb.a, mb.wd, mb.we, mb.cb, mb.done);
                    end
                end
            end else begin
                checks++;
                if (bus.mem_WE !== 1'b0 || bus.mem_A !== '0 || bus.mem_WD !== '0 ||
                    bus.mem_Cant_Byte !== 1'b0 || bus.r1_done !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_bus WE=%0b A=%h WD=%h CB=%0b done=%0b exp all 0",
                             bus.mem_WE, bus.mem_A, bus.mem_WD, bus.mem_Cant_Byte, bus.r1_done);
                end
            end
            if (bus.r0_rvalid || bus.r1_rvalid) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid r0=%0b r1=%0b", bus.r0_rvalid, bus.r1_rvalid);
                end else begin
                    mr = rd_q.pop_front();
                    if (bus.r0_rvalid !== (mr.who == 1'b0) || bus.r1_rvalid !== (mr.who == 1'b1) ||
                        (mr.who ? bus.r1_rdata : bus.r0_rdata) !== mr.d) begin
                        errors++;
                        $display("FAIL rdata got r0v=%0b r1v=%0b r0d=%h r1d=%h exp who=%0b d=%h",
                                 bus.r0_rvalid, bus.r1_rvalid, bus.r0_rdata, bus.r1_rdata, mr.who, mr.d);
                    end
                end
            end
        end
    end

    task automatic push_beat(input bit who, input logic [AW-1:0] a, input logic [AW-1:0] wd,
                             input bit we, input bit cb, input bit done);
        beat_t b;
        b.who = who; b.a = a; b.wd = wd; b.we = we; b.cb = cb; b.done = done;
        beat_q.push_back(b);
    endtask

    task automatic push_rd(input bit who, input logic [AW-1:0] d);
        rd_t r;
        r.who = who; r.d = d;
        rd_q.push_back(r);
    endtask

    // one CPU beat; grant is expected at the second negedge after the request
    task automatic r0_op(input bit we, input bit sz, input logic [AW-1:0] a,
                         input logic [AW-1:0] wd, input logic [AW-1:0] rexp);
        int n;
        bit got;
        push_beat(1'b0, a, wd, we, sz, 1'b0);
        if (!we) push_rd(1'b0, rexp);
        bus.r0_we = we; bus.r0_size = sz; bus.r0_addr = a; bus.r0_wdata = wd;
        bus.r0_req = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            got = bus.r0_gnt;
        end
        checks++;
        if (!got || n != 2) begin
            errors++;
            $display("FAIL r0_latency addr=%h got=%0b cycles=%0d required=2", a, got, n);
        end
        @(posedge clk); #1;
        bus.r0_req = 1'b0;
        bus.r0_wdata = '0;
    endtask

    // one DMA burst; optionally raises r0_req after the first beat
    task automatic r1_burst(input bit we, input bit sz, input logic [AW-1:0] a,
                            input logic [LENW-1:0] len, input logic [AW-1:0] wbase, input bit hold_r0);
        int nb, k, nc;
        bit fin, got;
        nb = (len == '0) ? 1 : int'(len);
        for (int i = 0; i < nb; i++) begin
            push_beat(1'b1, AW'(a + AW'(i * (sz ? 2 : 1))), we ? AW'(wbase + AW'(i)) : '0, we, sz, i == nb - 1);
        end
        if (hold_r0) push_beat(1'b0, 19'h00040, 19'h00005, 1'b1, 1'b0, 1'b0);
        bus.r1_we = we; bus.r1_size = sz; bus.r1_addr = a; bus.r1_len = len;
        bus.r1_wdata = we ? wbase : '0;
        bus.r1_req = 1'b1;
        k = 0; nc = 0; fin = 1'b0;
        while (!fin && nc < 100) begin
            @(negedge clk);
            nc++;
            if (bus.r1_gnt) begin
                k++;
                if (bus.r1_done) fin = 1'b1;
            end
            @(posedge clk); #1;
            if (fin) bus.r1_req = 1'b0;
            bus.r1_wdata = we ? AW'(wbase + AW'(k)) : '0;
            if (hold_r0 && k == 1) begin
                bus.r0_we = 1'b1; bus.r0_size = 1'b0; bus.r0_addr = 19'h00040; bus.r0_wdata = 19'h00005;
                bus.r0_req = 1'b1;
            end
        end
        checks++;
        if (!fin || k != nb) begin
            errors++;
            $display("FAIL r1_burst addr=%h done=%0b beats=%0d required=%0d", a, fin, k, nb);
        end
        if (hold_r0) begin
            got = 1'b0; nc = 0;
            while (!got && nc < 20) begin
                @(negedge clk);
                nc++;
                got = bus.r0_gnt;
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL r0_after_burst got=%0b required=1", got);
            end
            @(posedge clk); #1;
            bus.r0_req = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.r0_gnt !== 1'b0 || bus.r1_gnt !== 1'b0 || bus.r1_done !== 1'b0 ||
            bus.r0_rvalid !== 1'b0 || bus.r1_rvalid !== 1'b0 || bus.r0_rdata !== '0 ||
            bus.r1_rdata !== '0 || bus.mem_WE !== 1'b0 || bus.mem_A !== '0 ||
            bus.mem_WD !== '0 || bus.mem_Cant_Byte !== 1'b0) begin
            errors++;
            $display("FAIL %s g0=%0b g1=%0b done=%0b v0=%0b v1=%0b d0=%h d1=%h WE=%0b A=%h WD=%h CB=%0b exp all 0",
                     tag, bus.r0_gnt, bus.r1_gnt, bus.r1_done, bus.r0_rvalid, bus.r1_rvalid,
                     bus.r0_rdata, bus.r1_rdata, bus.mem_WE, bus.mem_A, bus.mem_WD, bus.mem_Cant_Byte);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0g, nc, k;
        bit r1d;

        bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_size = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
        bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_size = 1'b0; bus.r1_addr = '0; bus.r1_len = '0;
        bus.r1_wdata = '0;

        #12;
        check_reset_outputs("reset_state");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // CPU halfword write then read back
        r0_op(1'b1, 1'b1, 19'h00010, 19'h01234, '0);
        r0_op(1'b0, 1'b1, 19'h00010, '0, 19'h01234);

        // DMA halfword write burst, CPU blocked until it completes
        r1_burst(1'b1, 1'b1, 19'h00100, 4'd4, 19'h0000A, 1'b1);

        // byte read burst wrapping past the top of the address space
        r0_op(1'b1, 1'b0, 19'h7FFFE, 19'h00011, '0);
        r0_op(1'b1, 1'b0, 19'h7FFFF, 19'h00022, '0);
        r0_op(1'b1, 1'b0, 19'h00000, 19'h00033, '0);
        push_rd(1'b1, 19'h00011);
        push_rd(1'b1, 19'h00022);
        push_rd(1'b1, 19'h00033);
        r1_burst(1'b0, 1'b0, 19'h7FFFE, 4'd3, '0, 1'b0);

        // starvation: 4 CPU grants, then the DMA burst, then the CPU again
        for (int i = 0; i < 4; i++) push_beat(1'b0, 19'h00020, 19'h00055, 1'b1, 1'b1, 1'b0);
        push_beat(1'b1, 19'h00200, 19'h00077, 1'b1, 1'b1, 1'b0);
        push_beat(1'b1, 19'h00202, 19'h00077, 1'b1, 1'b1, 1'b1);
        push_beat(1'b0, 19'h00020, 19'h00055, 1'b1, 1'b1, 1'b0);
        bus.r0_we = 1'b1; bus.r0_size = 1'b1; bus.r0_addr = 19'h00020; bus.r0_wdata = 19'h00055;
        bus.r1_we = 1'b1; bus.r1_size = 1'b1; bus.r1_addr = 19'h00200; bus.r1_len = 4'd2;
        bus.r1_wdata = 19'h00077;
        bus.r0_req = 1'b1; bus.r1_req = 1'b1;
        r0g = 0; r1d = 1'b0; nc = 0;
        while (r0g < 5 && nc < 100) begin
            @(negedge clk);
            nc++;
            if (bus.r1_done) r1d = 1'b1;
            if (bus.r0_gnt) r0g++;
            @(posedge clk); #1;
            if (r1d) bus.r1_req = 1'b0;
        end
        bus.r0_req = 1'b0; bus.r1_req = 1'b0;
        checks++;
        if (r0g != 5 || !r1d) begin
            errors++;
            $display("FAIL starvation r0_grants=%0d r1_done=%0b required 5 and 1", r0g, r1d);
        end

        // zero length behaves as a single beat
        push_rd(1'b1, 19'h01234);
        r1_burst(1'b0, 1'b1, 19'h00010, 4'd0, '0, 1'b0);

        // reset during the second beat of a write burst
        r0_op(1'b1, 1'b1, 19'h00302, 19'h3AAAA, '0);
        push_beat(1'b1, 19'h00300, 19'h00001, 1'b1, 1'b1, 1'b0);
        push_beat(1'b1, 19'h00302, 19'h00002, 1'b1, 1'b1, 1'b0);
        bus.r1_we = 1'b1; bus.r1_size = 1'b1; bus.r1_addr = 19'h00300; bus.r1_len = 4'd4;
        bus.r1_wdata = 19'h00001;
        bus.r1_req = 1'b1;
        k = 0; nc = 0;
        while (k < 2 && nc < 50) begin
            @(negedge clk);
            nc++;
            if (bus.r1_gnt) k++;
            if (k < 2) begin
                @(posedge clk); #1;
                bus.r1_wdata = AW'(19'h00001 + AW'(k));
            end
        end
        checks++;
        if (k != 2) begin
            errors++;
            $display("FAIL reset_burst_start beats=%0d required=2", k);
        end
        #1 reset = 1'b0;
        #1 check_reset_outputs("reset_mid_burst");
        bus.r1_req = 1'b0;
        bus.r1_wdata = '0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset_held");
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        r0_op(1'b0, 1'b1, 19'h00302, '0, 19'h3AAAA);
        r0_op(1'b0, 1'b1, 19'h00300, '0, 19'h00001);

        nc = 0;
        while ((beat_q.size() != 0 || rd_q.size() != 0) && nc < 20) begin
            @(posedge clk);
            nc++;
        end
        checks++;
        if (beat_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL drain beats_left=%0d reads_left=%0d required 0 and 0", beat_q.size(), rd_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
